pipelined_addsub: RTL and testbench

Parametrised, pipelined add/subtract unit. It generalises the ripple-carry adder to WIDTH bits. The carry chain is split into STAGES registered segments. It adds subtract mode, a signed-overflow flag and a valid/ready handshake on both sides. It sits in the multimedia datapath as the shared arithmetic primitive for accumulators and filter taps, running at clock rates a full-width ripple chain cannot meet.

---
 rtl/pipelined_addsub.sv | 104 ++++++++++
 tb/tb_pipelined_addsub.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract unit: the carry chain is cut into STAGES
// registered segments, with a global-stall valid/ready handshake on both sides.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned SW = WIDTH / STAGES;

  // Per-stage source values: stage 0 sees the ports, stage k sees register k-1.
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;

  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [STAGES-1:0] carry_d, carry_q;
  logic [STAGES-1:0] valid_d, valid_q;
  logic              overflow_d, overflow_q;
  logic              advance;

  assign advance  = !valid_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  // b is inverted once at entry and carried as b'; subtract carry-in is ~cin.
  always_comb begin
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_c[0]   = cin ^ sub;
    src_v[0]   = in_valid;
    src_sum[0] = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_c[k]   = carry_q[k-1];
      src_v[k]   = valid_q[k-1];
      src_sum[k] = sum_q[k-1];
    end
  end

  always_comb begin
    logic [WIDTH-1:0] seg_a;
    logic [WIDTH-1:0] seg_b;
    logic [SW:0]      seg;
    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_a      = src_a[k] >> (k * SW);
      seg_b      = src_b[k] >> (k * SW);
      seg        = {1'b0, seg_a[SW-1:0]} + {1'b0, seg_b[SW-1:0]} + {{SW{1'b0}}, src_c[k]};
      sum_d[k]   = src_sum[k] | (WIDTH'(seg[SW-1:0]) << (k * SW));
      carry_d[k] = seg[SW];
      valid_d[k] = src_v[k];
      a_d[k]     = src_a[k];
      b_d[k]     = src_b[k];
    end
    overflow_d = (src_a[STAGES-1][WIDTH-1] == src_b[STAGES-1][WIDTH-1]) &&
                 (sum_d[STAGES-1][WIDTH-1] != src_a[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      carry_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else if (advance) begin
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed vectors, stall, reset flush
// and a random sweep with random back-pressure.
module tb_pipelined_addsub;
  parameter int unsigned STAGES = 4;
  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Entries are {cout, overflow, sum}.
  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] got, expv, held;
  bit               held_v = 1'b0;
  int unsigned      run_len = 0;
  int unsigned      max_run = 0;
  bit               sweep_on = 1'b0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, y,
                                             input logic c, s);
    int ua, ub, sa, sb, u, sv;
    logic cy, ov;
    logic [WIDTH-1:0] r;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    if (!s) begin
      u  = ua + ub + int'(c);
      sv = sa + sb + int'(c);
      cy = (u >= (1 << WIDTH));
    end else begin
      u  = ua - ub - int'(c);
      sv = sa - sb - int'(c);
      cy = (u >= 0);
    end
    ov = (sv > (1 << (WIDTH-1)) - 1) || (sv < -(1 << (WIDTH-1)));
    r  = u[WIDTH-1:0];
    return {cy, ov, r};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      got = {cout, overflow, sum};
      if (held_v) begin
        n_tests++;
        assert (got === held) else begin
          n_fail++;
          $error("FAIL hold got=%h exp=%h", got, held);
        end
      end
      if (out_ready) begin
        held_v = 1'b0;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        n_tests++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL extra_beat got=%h exp=none", got);
        end
        if (exp_q.size() > 0) begin
          expv = exp_q.pop_front();
          n_tests++;
          assert (got === expv) else begin
            n_fail++;
            $error("FAIL result got=%h exp=%h", got, expv);
          end
        end
      end else begin
        held   = got;
        held_v = 1'b1;
        run_len = 0;
        n_tests++;
        assert (in_ready === 1'b0) else begin
          n_fail++;
          $error("FAIL stall_in_ready got=%b exp=0", in_ready);
        end
      end
    end else begin
      held_v  = 1'b0;
      run_len = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [WIDTH-1:0] x, y, input logic c, s);
    int unsigned t = 0;
    bit done = 1'b0;
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    while (!done && t < 200) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(x, y, c, s));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      t++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $error("FAIL send_timeout got=stuck exp=accept");
    end
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    repeat (n) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain;
    int unsigned t = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    int unsigned lat;
    #3;
    n_tests++;
    assert ({out_valid, cout, overflow, sum} === '0) else begin
      n_fail++;
      $error("FAIL reset_state got=%b/%b/%b/%h exp=0", out_valid, cout, overflow, sum);
    end
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    assert (in_ready === 1'b1) else begin
      n_fail++;
      $error("FAIL in_ready_after_reset got=%b exp=1", in_ready);
    end

    // Carry through every segment, with latency measurement.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    assert (lat == STAGES) else begin
      n_fail++;
      $error("FAIL latency got=%0d exp=%0d", lat, STAGES);
    end
    @(posedge clk); #1;
    drain();

    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 1'b1, 1'b1);
    send(16'h8000, 16'h8000, 1'b1, 1'b0);
    drain();
    idle(2);

    // Back-to-back stream with no stall.
    max_run = 0;
    for (int i = 0; i < 8; i++) send(WIDTH'(i), 16'h0100, 1'b0, 1'(i % 2));
    drain();
    n_tests++;
    assert (max_run >= 8) else begin
      n_fail++;
      $error("FAIL stream_run got=%0d exp=8", max_run);
    end

    // Second stream with a 3-cycle downstream stall in the middle.
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        out_ready = 1'b0;
        fork
          send(WIDTH'(i + 32), 16'h0100, 1'b1, 1'(i % 2));
          begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
          end
        join
      end else begin
        send(WIDTH'(i + 32), 16'h0100, 1'b1, 1'(i % 2));
      end
    end
    drain();

    // Reset with beats in flight: all of them must be discarded.
    for (int i = 0; i < 4; i++) send(WIDTH'(16'h1234 + i), 16'h4321, 1'b0, 1'b0);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    assert ({out_valid, cout, overflow, sum} === '0) else begin
      n_fail++;
      $error("FAIL async_reset got=%b/%b/%b/%h exp=0", out_valid, cout, overflow, sum);
    end
    exp_q.delete();
    @(posedge clk); #3; rst_n = 1'b1;
    out_ready = 1'b1;
    idle(STAGES + 4);
    n_tests++;
    assert (exp_q.size() == 0 && out_valid === 1'b0) else begin
      n_fail++;
      $error("FAIL stale_after_reset got=%b exp=0", out_valid);
    end

    // Random sweep with random gaps and random back-pressure.
    sweep_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(3) == 0) idle(1);
          send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end
        sweep_on = 1'b0;
      end
      begin
        while (sweep_on) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom);
        end
      end
    join
    drain();
    idle(STAGES + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
